// File: rtl/wb_timer_pkg.sv
// wb_timer_pkg: shared definitions for the Wishbone machine-timer responder.
// Holds the register word offsets (ADR[4:2]), the bus FSM state type and the
// reset value of mtimecmp.
package wb_timer_pkg;

  // Word offsets within the 32-byte register window (ADR[4:2]).
  localparam logic [2:0] MTIME_LO    = 3'd0;
  localparam logic [2:0] MTIME_HI    = 3'd1;
  localparam logic [2:0] MTIMECMP_LO = 3'd2;
  localparam logic [2:0] MTIMECMP_HI = 3'd3;
  localparam logic [2:0] CTRL        = 3'd4;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } wb_slv_state_t;

  // mtimecmp resets to all ones so irq stays low until software programs it.
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/wb_timer_prescaler.sv
// wb_timer_prescaler: divides the clock into mtime increment ticks.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   en    in  count enable; en=0 freezes the counter
//   tick  out one-cycle pulse on the cycle the counter wraps (equals en when PRESCALE=1)
module wb_timer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  import wb_timer_pkg::*;

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_max_s;

  // Next count: 0..PRESCALE-1 while enabled, hold otherwise.
  always_comb begin
    cnt_d    = cnt_q;
    at_max_s = (cnt_q == CNT_MAX);
    if (en) begin
      if (at_max_s) begin
        cnt_d = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Tick on the wrap cycle; with PRESCALE=1 the counter sits at max so tick = en.
  assign tick = en & at_max_s;

endmodule

// File: rtl/wb_timer_slave.sv
// wb_timer_slave: Wishbone B4 classic-cycle responder exposing a 64-bit
// machine timer (mtime/mtimecmp) and a level timer interrupt.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   wb_adr   in   [31:0] address (region on [31:5], register on [4:2])
//   wb_dat_o in   [31:0] write data from the master
//   wb_we    in   write enable
//   wb_cyc   in   bus cycle
//   wb_stb   in   strobe
//   wb_dat_i out  [31:0] read data to the master (registered)
//   wb_ack   out  acknowledge, one cycle per accepted access (registered)
//   irq      out  timer interrupt, high while mtime >= mtimecmp (registered)
module wb_timer_slave #(
  parameter logic [31:0] BASE_ADDR = 32'hF000_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_o,
  input  logic        wb_we,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  output logic [31:0] wb_dat_i,
  output logic        wb_ack,
  output logic        irq
);
  import wb_timer_pkg::*;

  wb_slv_state_t state_q, state_d;
  logic          ack_q, ack_d;
  logic [31:0]   dat_q, dat_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic [31:0]   hi_shadow_q, hi_shadow_d;
  logic          en_q, en_d;
  logic          irq_q, irq_d;
  logic          sel_s;
  logic [2:0]    off_s;
  logic          tick_s;
  logic          unused_s;

  assign sel_s    = wb_cyc & wb_stb & (wb_adr[31:5] == BASE_ADDR[31:5]);
  assign off_s    = wb_adr[4:2];
  assign unused_s = &{1'b0, wb_adr[1:0]};

  wb_timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en_q),
    .tick  (tick_s)
  );

  // Bus FSM, register writes/reads, counting and interrupt compare.
  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    dat_d       = dat_q;
    mtime_d     = tick_s ? (mtime_q + 64'd1) : mtime_q;
    mtimecmp_d  = mtimecmp_q;
    hi_shadow_d = hi_shadow_q;
    en_d        = en_q;
    // Compare the registered values, so irq lags any register update by one cycle.
    irq_d       = (mtime_q >= mtimecmp_q);
    case (state_q)
      IDLE: begin
        if (sel_s) begin
          state_d = ACK;
          ack_d   = 1'b1;
          if (wb_we) begin
            // A write to either mtime half overrides the increment; the other
            // half keeps its pre-edge value, so no carry crosses halves.
            case (off_s)
              MTIME_LO:    mtime_d = {mtime_q[63:32], wb_dat_o};
              MTIME_HI:    mtime_d = {wb_dat_o, mtime_q[31:0]};
              MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], wb_dat_o};
              MTIMECMP_HI: mtimecmp_d = {wb_dat_o, mtimecmp_q[31:0]};
              CTRL:        en_d = wb_dat_o[0];
              default:     en_d = en_q;
            endcase
          end else begin
            case (off_s)
              MTIME_LO: begin
                // Snapshot the upper half so a later hi read is tear-free.
                dat_d       = mtime_q[31:0];
                hi_shadow_d = mtime_q[63:32];
              end
              MTIME_HI:    dat_d = hi_shadow_q;
              MTIMECMP_LO: dat_d = mtimecmp_q[31:0];
              MTIMECMP_HI: dat_d = mtimecmp_q[63:32];
              CTRL:        dat_d = {31'd0, en_q};
              default:     dat_d = 32'd0;
            endcase
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACK: begin
        // Requests seen here are ignored; the master must hold STB for the next slot.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      dat_q       <= 32'd0;
      mtime_q     <= 64'd0;
      mtimecmp_q  <= MTIMECMP_RST;
      hi_shadow_q <= 32'd0;
      en_q        <= 1'b1;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      hi_shadow_q <= hi_shadow_d;
      en_q        <= en_d;
      irq_q       <= irq_d;
    end
  end

  assign wb_ack   = ack_q;
  assign wb_dat_i = dat_q;
  assign irq      = irq_q;

endmodule
